// File: rtl/raybox_bridge_pkg.sv
// Shared constants for the Wishbone-to-SPI frame bridge: register map, field
// positions and the frame transmitter state encoding.
package raybox_bridge_pkg;

  localparam int MAX_BITS_DEF = 80;
  localparam int LEN_W        = 7;

  localparam logic [4:0] ADR_DATA0  = 5'h00;
  localparam logic [4:0] ADR_DATA1  = 5'h04;
  localparam logic [4:0] ADR_DATA2  = 5'h08;
  localparam logic [4:0] ADR_LEN    = 5'h0C;
  localparam logic [4:0] ADR_CTRL   = 5'h10;
  localparam logic [4:0] ADR_STATUS = 5'h14;

  localparam int CTRL_TGT     = 0;
  localparam int CTRL_GO      = 1;
  localparam int CTRL_DIV_LSB = 8;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_ERR     = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } tx_state_e;

endpackage

// File: rtl/spi_frame_tx.sv
// Mode-0, MSB-first SPI frame transmitter: one frame of i_len bits per start
// pulse, with every phase lasting (div+1) clocks.
module spi_frame_tx
  import raybox_bridge_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic [LEN_W-1:0]    i_len,
  input  logic [MAX_BITS-1:0] i_data,
  input  logic [7:0]          i_div,
  output logic                o_csb,
  output logic                o_sclk,
  output logic                o_mosi,
  output logic                o_busy
);

  tx_state_e           state_q, state_d;
  logic [7:0]          div_q, div_d, cnt_q, cnt_d;
  logic [LEN_W-1:0]    bits_q, bits_d;
  logic [MAX_BITS-1:0] shreg_q, shreg_d, loaded;
  logic                csb_q, csb_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic                half_done;

  assign half_done = (cnt_q == div_q);
  // Left-align the frame so bit LEN-1 sits at the shifter MSB.
  assign loaded    = i_data << (LEN_W'(MAX_BITS) - i_len);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    shreg_d = shreg_q;
    csb_d   = csb_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    if (state_q != ST_IDLE) cnt_d = half_done ? '0 : cnt_q + 8'd1;
    case (state_q)
      ST_IDLE: if (i_start) begin
        state_d = ST_SETUP;
        div_d   = i_div;
        cnt_d   = '0;
        bits_d  = i_len;
        shreg_d = loaded;
        csb_d   = 1'b0;
        sclk_d  = 1'b0;
        mosi_d  = loaded[MAX_BITS-1];
      end
      ST_SETUP: if (half_done) begin
        state_d = ST_SHIFT;
        sclk_d  = 1'b1;
      end
      // The low half after the last falling edge completes before HOLD.
      ST_SHIFT: if (half_done) begin
        if (sclk_q) begin
          sclk_d  = 1'b0;
          shreg_d = shreg_q << 1;
          mosi_d  = shreg_q[MAX_BITS-2];
          bits_d  = bits_q - LEN_W'(1);
        end else if (bits_q == '0) begin
          state_d = ST_HOLD;
        end else begin
          sclk_d = 1'b1;
        end
      end
      ST_HOLD: if (half_done) begin
        state_d = ST_GAP;
        csb_d   = 1'b1;
        mosi_d  = 1'b0;
      end
      ST_GAP: if (half_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      bits_q  <= '0;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      csb_q   <= csb_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  always_ff @(posedge i_clk) shreg_q <= shreg_d;

  assign o_csb  = csb_q;
  assign o_sclk = sclk_q;
  assign o_mosi = mosi_q;
  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: rtl/wb_spi_frame_bridge.sv
// Wishbone slave register file that launches SPI frames into the renderer's
// reg or vec port; the idle port is held at csb=1, sclk=0, mosi=0.
module wb_spi_frame_bridge
  import raybox_bridge_pkg::*;
#(
  parameter int         MAX_BITS = MAX_BITS_DEF,
  parameter logic [7:0] DIV_RST  = 8'd1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_dat,
  output logic        o_reg_csb,
  output logic        o_reg_sclk,
  output logic        o_reg_mosi,
  output logic        o_vec_csb,
  output logic        o_vec_sclk,
  output logic        o_vec_mosi,
  output logic        o_busy
);

  logic             ack_q, ack_d;
  logic [31:0]      rdat_q, rdat_d, rd_mux;
  logic [31:0]      data0_q, data0_d, data1_q, data1_d;
  logic [15:0]      data2_q, data2_d;
  logic [LEN_W-1:0] len_q, len_d, len_wr;
  logic [7:0]       div_q, div_d;
  logic             tgt_q, tgt_d, tgt_act_q, tgt_act_d, err_q, err_d;
  logic             req, wr_en, busy, start;
  logic [4:0]       adr_w;
  logic [79:0]      frame;
  logic             tx_csb, tx_sclk, tx_mosi;
  logic             unused_adr;

  assign unused_adr = ^i_wb_adr[1:0];
  assign adr_w      = {i_wb_adr[4:2], 2'b00};
  assign req        = i_wb_cyc & i_wb_stb & ~ack_q;
  // Writes commit in the ack cycle so a GO acked at T starts the frame at T+1.
  assign wr_en      = i_wb_cyc & i_wb_stb & i_wb_we & ack_q;
  assign len_wr     = (i_wb_dat[LEN_W-1:0] > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS)
                                                               : i_wb_dat[LEN_W-1:0];
  assign frame      = {data2_q, data1_q, data0_q};

  always_comb begin
    rd_mux = '0;
    case (adr_w)
      ADR_DATA0:  rd_mux = data0_q;
      ADR_DATA1:  rd_mux = data1_q;
      ADR_DATA2:  rd_mux[15:0] = data2_q;
      ADR_LEN:    rd_mux[LEN_W-1:0] = len_q;
      ADR_CTRL: begin
        rd_mux[CTRL_TGT]          = tgt_q;
        rd_mux[CTRL_DIV_LSB +: 8] = div_q;
      end
      ADR_STATUS: begin
        rd_mux[STAT_BUSY] = busy;
        rd_mux[STAT_ERR]  = err_q;
      end
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    ack_d     = req;
    rdat_d    = (req & ~i_wb_we) ? rd_mux : '0;
    data0_d   = data0_q;
    data1_d   = data1_q;
    data2_d   = data2_q;
    len_d     = len_q;
    div_d     = div_q;
    tgt_d     = tgt_q;
    tgt_act_d = tgt_act_q;
    err_d     = err_q;
    start     = 1'b0;
    if (wr_en) begin
      if (busy && (adr_w <= ADR_CTRL)) begin
        err_d = 1'b1;
      end else begin
        case (adr_w)
          ADR_DATA0: data0_d = i_wb_dat;
          ADR_DATA1: data1_d = i_wb_dat;
          ADR_DATA2: data2_d = i_wb_dat[15:0];
          ADR_LEN:   len_d   = len_wr;
          ADR_CTRL: begin
            tgt_d = i_wb_dat[CTRL_TGT];
            div_d = i_wb_dat[CTRL_DIV_LSB +: 8];
            if (i_wb_dat[CTRL_GO]) begin
              if (len_q == '0) begin
                err_d = 1'b1;
              end else begin
                start     = 1'b1;
                tgt_act_d = i_wb_dat[CTRL_TGT];
              end
            end
          end
          ADR_STATUS: if (i_wb_dat[STAT_ERR]) err_d = 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ack_q     <= 1'b0;
      rdat_q    <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
      data2_q   <= '0;
      len_q     <= '0;
      div_q     <= DIV_RST;
      tgt_q     <= 1'b0;
      tgt_act_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      rdat_q    <= rdat_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      len_q     <= len_d;
      div_q     <= div_d;
      tgt_q     <= tgt_d;
      tgt_act_q <= tgt_act_d;
      err_q     <= err_d;
    end
  end

  spi_frame_tx #(.MAX_BITS(MAX_BITS)) u_tx (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (start),
    .i_len     (len_q),
    .i_data    (frame[MAX_BITS-1:0]),
    .i_div     (div_d),
    .o_csb     (tx_csb),
    .o_sclk    (tx_sclk),
    .o_mosi    (tx_mosi),
    .o_busy    (busy)
  );

  // Target only changes at GO, while the transmitter drives idle levels.
  assign o_reg_csb  = tgt_act_q | tx_csb;
  assign o_reg_sclk = ~tgt_act_q & tx_sclk;
  assign o_reg_mosi = ~tgt_act_q & tx_mosi;
  assign o_vec_csb  = ~tgt_act_q | tx_csb;
  assign o_vec_sclk = tgt_act_q & tx_sclk;
  assign o_vec_mosi = tgt_act_q & tx_mosi;

  assign o_wb_ack = ack_q;
  assign o_wb_dat = rdat_q;
  assign o_busy   = busy;

endmodule

// File: doc/wb_spi_frame_bridge.md
# wb_spi_frame_bridge

Wishbone-slave bridge that lets the Caravel management core load the renderer's two SPI register ports (`reg` and `vec`) instead of bit-banging them through logic-analyser pins. Software writes up to 80 payload bits, a length, a target and a go bit. The bridge then emits one mode-0, MSB-first SPI frame on the selected port's csb/sclk/mosi outputs. It sits directly upstream of the renderer's `i_reg_*` / `i_vec_*` inputs, with the wrapper muxing it against the LA lines.

## Interface
- `MAX_BITS`, 80: shift-register width; max frame length.
- `DIV_RST`, 1: reset value of the clock divider field.
- `i_clk` in 1: system clock (wb_clk_i).
- `i_reset_n` in 1: reset, asynchronous and active-low.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we` in 1: Wishbone classic strobes.
- `i_wb_adr` in 5: byte address bits [4:0]. Word-aligned; bits [1:0] ignored.
- `i_wb_dat` in 32: write data. `i_wb_sel` is not used; all writes are full-word.
- `o_wb_ack` out 1: single-cycle acknowledge.
- `o_wb_dat` out 32: read data.
- `o_reg_csb`, `o_reg_sclk`, `o_reg_mosi` out 1 each: SPI to the renderer register port.
- `o_vec_csb`, `o_vec_sclk`, `o_vec_mosi` out 1 each: SPI to the renderer vector port.
- `o_busy` out 1: frame in progress.

## Operation
- Register map, by word offset:
  - 0x00 DATA0: frame bits [31:0].
  - 0x04 DATA1: frame bits [63:32].
  - 0x08 DATA2: bits [15:0] hold frame bits [79:64]; bits [31:16] read 0.
  - 0x0C LEN: bits [6:0] hold the bit count.
  - 0x10 CTRL: bit0 TARGET (0=reg, 1=vec), bit1 GO (write-only, reads 0), bits [15:8] DIV.
  - 0x14 STATUS: bit0 BUSY, bit1 ERR (sticky). Writing 1 to bit1 clears ERR.
  - All other offsets read 0 and ignore writes.
- Frame contents: the frame is bits [LEN-1:0] of the 80-bit data. Bit LEN-1 is sent first.
- Write rejection:
  - While BUSY, writes to DATA, LEN and CTRL are acked but ignored, and ERR is set.
  - GO with LEN=0 is ignored and sets ERR.
  - LEN > 80 is clamped to 80 when the write is stored.
- FSM states: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE. Half-period H = DIV+1 clocks.
  - IDLE: accepted GO latches TARGET, LEN and DATA into the shifter and bit counter. Go to SETUP.
  - SETUP (H clocks): selected csb=0, sclk=0, mosi = first bit.
  - SHIFT: sclk toggles every H clocks, starting with a rising edge. mosi changes only on the clock where sclk falls. After the LEN-th falling edge, go to HOLD.
  - HOLD (H clocks): sclk=0, csb=0. At the end of HOLD, csb rises.
  - GAP (H clocks): csb=1. Then return to IDLE and clear BUSY.
- The non-selected port holds csb=1, sclk=0, mosi=0 throughout.
- All SPI outputs are registered.
- Reset values:
  - Both csb = 1; both sclk and mosi = 0.
  - `o_wb_ack` = 0, `o_wb_dat` = 0, `o_busy` = 0, ERR = 0.
  - DATA = 0, LEN = 0, TARGET = 0, DIV = DIV_RST.
- Reset mid-frame: outputs return to their reset values asynchronously; no partial frame is completed.

## Timing
- `o_wb_ack` asserts exactly one cycle after a cycle with cyc&stb&!ack. It is high for one cycle.
- Back-to-back strobes are acked on alternate cycles.
- Read data is valid in the ack cycle.
- The GO write is acked in cycle T. BUSY and `o_busy` are high from T+1.
- The selected csb falls at T+1.
- The first sclk rise is at T+1+H.
- csb rises at T+1+H+2·LEN·H+H.
- BUSY clears at T+1+(2·LEN+3)·H.
- A STATUS read in the same cycle that BUSY clears returns the pre-clear value.
- DIV changes take effect only on the next GO.

## Structure
- Shared package `raybox_bridge_pkg`:
  - Register offset constants.
  - CTRL/STATUS bit positions.
  - FSM state enum.
  - `MAX_BITS` default.
- One natural sub-module, `spi_frame_tx`, containing:
  - The FSM.
  - The divider counter.
  - The shifter.
  - The bit counter.
- The top level holds the Wishbone decode and register file, and steers `spi_frame_tx` outputs to the reg or vec pins.

## Test plan
- Reset: after `i_reset_n` is released, both csb=1, sclk=0, mosi=0. STATUS reads 0x0 and CTRL reads 0x100 (DIV=1).
- Basic reg frame:
  - Setup: DATA0=0xA5, LEN=8, DIV=0, then GO with TARGET=0.
  - Check: reg port shifts 1,0,1,0,0,1,0,1 on sclk rising edges.
  - Check: csb is low for 2+16 clocks and BUSY lasts 19 clocks.
  - Check: vec port stays idle.
- 80-bit vec frame:
  - Setup: DATA2=0x8001, DATA1=0, DATA0=1, LEN=80, DIV=3, TARGET=1.
  - Check: the first and last vec bits are 1 and the 16th bit is 1.
  - Check: 80 rising edges, each 8 clocks apart.
- Rejections:
  - GO with LEN=0 → no csb activity and ERR=1; writing 0x2 to STATUS clears ERR.
  - LEN=100 → LEN reads back 80.
- Write while busy: write DATA0 during a frame → ack is returned, the shifted bits are unchanged, and ERR=1.
- Reset mid-frame: drop `i_reset_n` during SHIFT → csb goes high asynchronously and BUSY=0. A new frame after release transmits correctly.
